// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slow off-chip memory port between the instruction-side and
//   data-side L2 miss/write-back interfaces. One transaction at a time,
//   round-robin (or D-biased) arbitration, a mandatory one-cycle release gap
//   between transactions, and a sticky watchdog for hung transactions.
//
// Ports
//   clk, proc_reset          clock (rising edge), synchronous active-high reset
//   i_mem_read/write/addr/wdata  I-side request, held until i_mem_ready
//   i_mem_rdata/ready        I-side read line and completion strobe
//   d_mem_*                  same as i_mem_*, D-side
//   mem_read/write/addr/wdata    request to slow memory (0 outside a grant)
//   mem_rdata/ready          slow memory read line and 1-cycle completion
//   grant_i, grant_d         current owner of the memory port
//   timeout_err              sticky watchdog flag, cleared only by reset
//
// State     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; arbitrate among current requests
// GRANT_I   | I-side owns the memory port
// GRANT_D   | D-side owns the memory port
// RELEASE   | one dead cycle so a finishing side's stale request is dropped
module mem_port_arbiter #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024,
  parameter int FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_i,
  output logic              grant_d,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic            r_last_d;
  logic            w_next_last_d;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;

  logic w_req_i;
  logic w_req_d;
  logic w_granted;

  assign w_req_i   = i_mem_read | i_mem_write;
  assign w_req_d   = d_mem_read | d_mem_write;
  assign w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);

  always_comb begin
    w_next_state  = r_state;
    w_next_last_d = r_last_d;
    case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) begin
          // Tie: the side that did not finish last wins, unless D is pinned.
          w_next_state = ((FIXED_PRIO != 0) || !r_last_d) ? GRANT_D : GRANT_I;
        end else if (w_req_i) begin
          w_next_state = GRANT_I;
        end else if (w_req_d) begin
          w_next_state = GRANT_D;
        end
      end
      GRANT_I: begin
        if (mem_ready) begin
          w_next_state  = RELEASE;
          w_next_last_d = 1'b0;
        end else if (!w_req_i) begin
          w_next_state  = RELEASE;
        end
      end
      GRANT_D: begin
        if (mem_ready) begin
          w_next_state  = RELEASE;
          w_next_last_d = 1'b1;
        end else if (!w_req_d) begin
          w_next_state  = RELEASE;
        end
      end
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (r_state)
      GRANT_I: begin
        mem_write   = i_mem_write;
        mem_read    = i_mem_read & ~i_mem_write;
        mem_addr    = i_mem_addr;
        mem_wdata   = i_mem_wdata;
        i_mem_ready = mem_ready;
      end
      GRANT_D: begin
        mem_write   = d_mem_write;
        mem_read    = d_mem_read & ~d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready;
      end
      default: ;
    endcase
  end

  // Read data is not qualified here; the ready strobe is the only qualifier.
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign grant_i     = (r_state == GRANT_I);
  assign grant_d     = (r_state == GRANT_D);
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      r_state       <= IDLE;
      r_last_d      <= 1'b1;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_last_d <= w_next_last_d;
      // Grants are only ever entered from IDLE, so clearing there is
      // equivalent to clearing on grant entry.
      if (r_state == IDLE) begin
        r_wd_cnt <= '0;
      end else if (w_granted && !mem_ready) begin
        if (r_wd_cnt == WD_LAST) begin
          r_timeout_err <= 1'b1;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          proc_reset;
  logic          i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [AW-1:0] i_mem_addr, d_mem_addr;
  logic [DW-1:0] i_mem_wdata, d_mem_wdata;
  logic          mem_ready_s [2];
  logic [DW-1:0] mem_rdata_s [2];

  logic [DW-1:0] o_i_rdata [2];
  logic [DW-1:0] o_d_rdata [2];
  logic          o_i_ready [2];
  logic          o_d_ready [2];
  logic          o_mem_read [2];
  logic          o_mem_write [2];
  logic [AW-1:0] o_mem_addr [2];
  logic [DW-1:0] o_mem_wdata [2];
  logic          o_grant_i [2];
  logic          o_grant_d [2];
  logic          o_terr [2];

  // Instance 0 is round-robin, instance 1 has fixed D priority.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO), .FIXED_PRIO(g)
    ) u_dut (
      .clk(clk), .proc_reset(proc_reset),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
      .i_mem_rdata(o_i_rdata[g]), .i_mem_ready(o_i_ready[g]),
      .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
      .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
      .d_mem_rdata(o_d_rdata[g]), .d_mem_ready(o_d_ready[g]),
      .mem_read(o_mem_read[g]), .mem_write(o_mem_write[g]),
      .mem_addr(o_mem_addr[g]), .mem_wdata(o_mem_wdata[g]),
      .mem_rdata(mem_rdata_s[g]), .mem_ready(mem_ready_s[g]),
      .grant_i(o_grant_i[g]), .grant_d(o_grant_d[g]),
      .timeout_err(o_terr[g])
    );
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the port (0 none, 1 I, 2 D), whether the
  // mandatory gap is pending, who finished last, and grant-cycles waited.
  int m_owner [2];
  bit m_gap [2];
  bit m_last_d [2];
  int m_wait [2];
  bit m_terr [2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    bit ri, rd, rq;
    ri = i_mem_read | i_mem_write;
    rd = d_mem_read | d_mem_write;
    for (int k = 0; k < 2; k++) begin
      if (proc_reset) begin
        m_owner[k] = 0; m_gap[k] = 0; m_last_d[k] = 1; m_wait[k] = 0; m_terr[k] = 0;
      end else if (m_gap[k]) begin
        m_gap[k] = 0;
      end else if (m_owner[k] == 0) begin
        if (ri && rd)  m_owner[k] = (k == 1) ? 2 : (m_last_d[k] ? 1 : 2);
        else if (ri)   m_owner[k] = 1;
        else if (rd)   m_owner[k] = 2;
        m_wait[k] = 0;
      end else begin
        rq = (m_owner[k] == 1) ? ri : rd;
        if (mem_ready_s[k]) begin
          m_last_d[k] = (m_owner[k] == 2);
          m_owner[k] = 0; m_gap[k] = 1;
        end else begin
          m_wait[k] = m_wait[k] + 1;
          if (m_wait[k] >= TO) m_terr[k] = 1;
          if (!rq) begin m_owner[k] = 0; m_gap[k] = 1; end
        end
      end
    end
    if (proc_reset) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [34:0]   c_exp, c_act;
    logic [3*DW-1:0] d_exp, d_act;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = '0; e_wd = '0;
        if (m_owner[k] == 1) begin
          e_wr = i_mem_write; e_rd = i_mem_read & ~i_mem_write;
          e_addr = i_mem_addr; e_wd = i_mem_wdata; e_ir = mem_ready_s[k];
        end else if (m_owner[k] == 2) begin
          e_wr = d_mem_write; e_rd = d_mem_read & ~d_mem_write;
          e_addr = d_mem_addr; e_wd = d_mem_wdata; e_dr = mem_ready_s[k];
        end
        c_exp = {e_rd, e_wr, e_ir, e_dr, m_owner[k] == 1, m_owner[k] == 2, m_terr[k], e_addr};
        c_act = {o_mem_read[k], o_mem_write[k], o_i_ready[k], o_d_ready[k],
                 o_grant_i[k], o_grant_d[k], o_terr[k], o_mem_addr[k]};
        d_exp = {e_wd, mem_rdata_s[k], mem_rdata_s[k]};
        d_act = {o_mem_wdata[k], o_i_rdata[k], o_d_rdata[k]};
        n_checks += 2;
        if (c_act !== c_exp) begin
          n_errs++;
          $display("FAIL inst%0d ctrl at %0t: got %h expected %h", k, $time, c_act, c_exp);
        end
        if (d_act !== d_exp) begin
          n_errs++;
          $display("FAIL inst%0d data at %0t: got %h expected %h", k, $time, d_act, d_exp);
        end
      end
    end
  end

  // Auto-responder: completes each grant on its second cycle.
  bit auto_on = 1'b0;
  int gcnt [2] = '{0, 0};
  always begin
    @(posedge clk);
    #2;
    if (auto_on) begin
      for (int k = 0; k < 2; k++) begin
        gcnt[k] = (o_grant_i[k] || o_grant_d[k]) ? gcnt[k] + 1 : 0;
        mem_ready_s[k] = (gcnt[k] == 2);
        mem_rdata_s[k] = {4{32'h0BAD_F00D}};
      end
    end
  end

  // Grant-start recorder (1 = I, 2 = D).
  bit rec_on = 1'b0;
  int seq0[$];
  int seq1[$];
  bit p_gi [2] = '{0, 0};
  bit p_gd [2] = '{0, 0};
  always @(negedge clk) begin
    if (rec_on) begin
      if (o_grant_i[0] && !p_gi[0]) seq0.push_back(1);
      if (o_grant_d[0] && !p_gd[0]) seq0.push_back(2);
      if (o_grant_i[1] && !p_gi[1]) seq1.push_back(1);
      if (o_grant_d[1] && !p_gd[1]) seq1.push_back(2);
    end
    for (int k = 0; k < 2; k++) begin
      p_gi[k] = o_grant_i[k]; p_gd[k] = o_grant_d[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic rdy, input logic [DW-1:0] dat);
    mem_ready_s[0] = rdy; mem_ready_s[1] = rdy;
    mem_rdata_s[0] = dat; mem_rdata_s[1] = dat;
  endtask

  task automatic clr_in();
    i_mem_read = 0; i_mem_write = 0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_addr = '0; d_mem_wdata = '0;
    set_mem(1'b0, {4{32'h1357_9BDF}});
  endtask

  // Leaves the bench at cycle 0 (IDLE, inputs cleared) right after reset.
  task automatic do_reset();
    tick();
    proc_reset = 1;
    clr_in();
    tick();
    proc_reset = 0;
  endtask

  localparam logic [DW-1:0] DBEEF = 128'hDEAD0000_01234567_89ABCDEF_0000BEEF;
  localparam logic [DW-1:0] PA5   = {16{8'hA5}};

  initial begin
    int exp_rr [6];
    proc_reset = 1;
    clr_in();
    do_reset();

    @(negedge clk);
    chk("reset grant_i", 128'(o_grant_i[0]), 128'(0));
    chk("reset mem_read", 128'(o_mem_read[0]), 128'(0));
    chk("reset timeout_err", 128'(o_terr[0]), 128'(0));

    // Single I read with held-over stale request.
    tick(); i_mem_read = 1; i_mem_addr = 28'h0000123;
    // wait: that tick moved to cycle 1 of nothing; restart cleanly
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000123;           // cycle 0
    tick(); @(negedge clk);                              // cycle 1
    chk("t1 mem_read c1", 128'(o_mem_read[0]), 128'(1));
    chk("t1 mem_addr c1", 128'(o_mem_addr[0]), 128'(28'h0000123));
    tick(); tick(); tick(); @(negedge clk);              // cycle 4
    chk("t1 i_ready c4", 128'(o_i_ready[0]), 128'(0));
    tick(); set_mem(1'b1, DBEEF); @(negedge clk);        // cycle 5
    chk("t1 i_ready c5", 128'(o_i_ready[0]), 128'(1));
    chk("t1 i_rdata c5", o_i_rdata[0], DBEEF);
    chk("t1 d_ready c5", 128'(o_d_ready[0]), 128'(0));
    tick(); set_mem(1'b0, DBEEF); @(negedge clk);        // cycle 6 RELEASE
    chk("t1 release mem_read", 128'(o_mem_read[0]), 128'(0));
    chk("t1 release grant_i", 128'(o_grant_i[0]), 128'(0));
    tick(); i_mem_read = 0; tick(); @(negedge clk);      // cycle 8
    chk("t1 no regrant", 128'(o_grant_i[0]), 128'(0));

    // Simultaneous I read / D write after reset.
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000010;
    d_mem_write = 1; d_mem_addr = 28'h0000040; d_mem_wdata = PA5;
    tick(); @(negedge clk);                              // cycle 1
    chk("t2 grant_i first", 128'(o_grant_i[0]), 128'(1));
    chk("t2 grant_d not first", 128'(o_grant_d[0]), 128'(0));
    chk("t2 fixed grant_d first", 128'(o_grant_d[1]), 128'(1));
    tick(); set_mem(1'b1, DBEEF); @(negedge clk);        // cycle 2
    chk("t2 i_ready", 128'(o_i_ready[0]), 128'(1));
    tick(); set_mem(1'b0, DBEEF); i_mem_read = 0;        // cycle 3
    @(negedge clk);
    chk("t2 release grant_d", 128'(o_grant_d[0]), 128'(0));
    tick(); tick(); @(negedge clk);                      // cycle 5
    chk("t2 grant_d", 128'(o_grant_d[0]), 128'(1));
    chk("t2 mem_write", 128'(o_mem_write[0]), 128'(1));
    chk("t2 mem_wdata", o_mem_wdata[0], PA5);
    chk("t2 mem_addr", 128'(o_mem_addr[0]), 128'(28'h0000040));
    tick(); set_mem(1'b1, DBEEF); @(negedge clk);        // cycle 6
    chk("t2 d_ready", 128'(o_d_ready[0]), 128'(1));
    tick(); set_mem(1'b0, DBEEF); d_mem_write = 0;

    // Fairness with both sides requesting continuously.
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000200;
    d_mem_write = 1; d_mem_addr = 28'h0000300; d_mem_wdata = PA5;
    auto_on = 1; rec_on = 1;
    repeat (40) tick();
    auto_on = 0; rec_on = 0;
    clr_in();
    tick(); tick(); tick();
    exp_rr = '{1, 2, 1, 2, 1, 2};
    chk("rr count", 128'(seq0.size() >= 6), 128'(1));
    chk("fixed count", 128'(seq1.size() >= 6), 128'(1));
    for (int n = 0; n < 6; n++) begin
      if (n < seq0.size()) chk($sformatf("rr order %0d", n), 128'(seq0[n]), 128'(exp_rr[n]));
      if (n < seq1.size()) chk($sformatf("fixed order %0d", n), 128'(seq1[n]), 128'(2));
    end

    // Watchdog: memory never answers.
    do_reset();
    i_mem_read = 1; i_mem_addr = 28'h0000007;
    repeat (8) tick();
    @(negedge clk);                                      // cycle 8
    chk("wd not yet", 128'(o_terr[0]), 128'(0));
    chk("wd grant held c8", 128'(o_grant_i[0]), 128'(1));
    tick(); @(negedge clk);                              // cycle 9
    chk("wd set", 128'(o_terr[0]), 128'(1));
    tick(); tick(); tick(); set_mem(1'b1, DBEEF);        // cycle 12
    @(negedge clk);
    chk("wd grant held c12", 128'(o_grant_i[0]), 128'(1));
    chk("wd late ready", 128'(o_i_ready[0]), 128'(1));
    tick(); set_mem(1'b0, DBEEF); i_mem_read = 0;
    tick(); tick(); @(negedge clk);                      // cycle 15
    chk("wd sticky", 128'(o_terr[0]), 128'(1));
    do_reset();
    @(negedge clk);
    chk("wd cleared", 128'(o_terr[0]), 128'(0));

    // Abort then late ready.
    d_mem_read = 1; d_mem_addr = 28'h0000055;            // cycle 0
    tick(); @(negedge clk);                              // cycle 1
    chk("ab grant_d", 128'(o_grant_d[0]), 128'(1));
    tick(); tick(); d_mem_read = 0;                      // cycle 3
    tick(); set_mem(1'b1, DBEEF); @(negedge clk);        // cycle 4
    chk("ab late ready", 128'(o_d_ready[0]), 128'(0));
    chk("ab release grant", 128'(o_grant_d[0]), 128'(0));
    tick(); set_mem(1'b0, DBEEF);                        // cycle 5
    i_mem_read = 1; i_mem_addr = 28'h0000066;
    tick(); @(negedge clk);                              // cycle 6
    chk("ab next grant_i", 128'(o_grant_i[0]), 128'(1));
    chk("ab next addr", 128'(o_mem_addr[0]), 128'(28'h0000066));
    tick(); set_mem(1'b1, DBEEF); @(negedge clk);        // cycle 7
    chk("ab next i_ready", 128'(o_i_ready[0]), 128'(1));
    tick(); clr_in();

    // Reset during GRANT_D.
    do_reset();
    d_mem_write = 1; d_mem_addr = 28'h0000099; d_mem_wdata = PA5;
    tick(); tick(); proc_reset = 1; @(negedge clk);      // cycle 2
    chk("rst before edge grant_d", 128'(o_grant_d[0]), 128'(1));
    tick(); proc_reset = 0; d_mem_write = 0; set_mem(1'b1, DBEEF);
    @(negedge clk);                                      // cycle 3
    chk("rst grant_d", 128'(o_grant_d[0]), 128'(0));
    chk("rst mem_write", 128'(o_mem_write[0]), 128'(0));
    chk("rst mem_addr", 128'(o_mem_addr[0]), 128'(0));
    chk("rst d_ready", 128'(o_d_ready[0]), 128'(0));
    tick(); set_mem(1'b0, DBEEF); @(negedge clk);
    chk("rst idle", 128'(o_grant_d[0] | o_grant_i[0]), 128'(0));

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single slow off-chip memory port between the instruction-side and data-side L2 cache miss/write-back interfaces.
- Sits between the two L2 cache memory ports and the external slow memory, so one memory can serve both hierarchies.
- Round-robin arbitration, one transaction at a time, with a mandatory release cycle between transactions and a sticky watchdog for hung transactions.

Parameters:
- ADDR_W, 28, block address width (address bits 31:4).
- DATA_W, 128, line width.
- TIMEOUT_CYC, 1024, grant cycles without mem_ready before timeout_err sets.
- FIXED_PRIO, 0, 0 = round-robin; 1 = D-side always wins ties.

Ports:
- clk  in  1  clock, rising edge.
- proc_reset  in  1  synchronous active-high reset.
- i_mem_read  in  1  I-side read request; held until i_mem_ready.
- i_mem_write  in  1  I-side write request; held until i_mem_ready.
- i_mem_addr  in  ADDR_W  I-side block address.
- i_mem_wdata  in  DATA_W  I-side write line.
- i_mem_rdata  out  DATA_W  read line to I-side.
- i_mem_ready  out  1  completion strobe to I-side.
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same as the i_ ports, D-side.
- mem_read  out  1  to slow memory.
- mem_write  out  1  to slow memory.
- mem_addr  out  ADDR_W  to slow memory.
- mem_wdata  out  DATA_W  to slow memory.
- mem_rdata  in  DATA_W  from slow memory.
- mem_ready  in  1  from slow memory; 1-cycle completion strobe.
- grant_i  out  1  state == GRANT_I.
- grant_d  out  1  state == GRANT_D.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Clock is clk. Reset is proc_reset: synchronous, active-high.
- Reset state:
  - state = IDLE, last = D (so I wins the first tie), wd_cnt = 0, timeout_err = 0.
  - All memory-side outputs and both x_mem_ready = 0.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Request definition: req_x = x_mem_read | x_mem_write.
- IDLE transitions, registered on the next edge:
  - Only one side requesting: grant that side.
  - Both requesting: grant the side != last (round-robin), or D when FIXED_PRIO = 1.
  - Neither requesting: stay in IDLE.
- Latency: a request first seen in IDLE at cycle T drives the memory port at T+1.
- GRANT_x datapath (combinational mux from the granted side):
  - mem_addr = x_mem_addr, mem_wdata = x_mem_wdata.
  - mem_write = x_mem_write.
  - mem_read = x_mem_read & ~x_mem_write: write wins if both are asserted.
  - Non-granted side sees x_mem_ready = 0.
- Outside GRANT states, memory-side outputs are all 0.
- Read data: mem_rdata is fanned out unconditionally to i_mem_rdata and d_mem_rdata. Only the ready strobe qualifies it.
- Completion:
  - In GRANT_x with mem_ready = 1: x_mem_ready = 1 in the same cycle (combinational).
  - Next state = RELEASE; last = x.
- Abort: in GRANT_x with req_x = 0 and mem_ready = 0, go to RELEASE without a ready strobe. Any later mem_ready in RELEASE or IDLE is ignored and not forwarded.
- RELEASE:
  - Exactly 1 cycle with all memory outputs = 0, then IDLE.
  - Guarantees the finishing requester's stale request (still high in the ready cycle) is never re-granted.
  - A new request therefore reaches the memory no earlier than 3 cycles after the previous mem_ready.
- Watchdog:
  - wd_cnt clears on entry to GRANT_x; increments each GRANT cycle without mem_ready.
  - At wd_cnt == TIMEOUT_CYC-1 with no ready, timeout_err sets and stays 1 until proc_reset. The grant is not revoked.
  - wd_cnt saturates.
- Reset mid-transaction: the next edge forces IDLE, clears outputs and timeout_err, and drops the grant. An in-flight mem_ready after reset is ignored.
- Starvation bound (round-robin): a waiting requester is granted after at most one transaction of the other side.

Test Plan:
- Single I read:
  - Stimulus: i_mem_read = 1, addr 0x0000123 at cycle 0; memory returns ready at cycle 5 with data 0xDEAD…BEEF.
  - Required: mem_read = 1, mem_addr = 0x0000123 during cycles 1–5; i_mem_ready = 1 only at cycle 5; i_mem_rdata = 0xDEAD…BEEF; d_mem_ready stays 0.
- Simultaneous requests after reset:
  - Stimulus: I read and D write (addr 0x0000040, data pattern A5) at cycle 0.
  - Required: I granted first; D granted after the RELEASE cycle; mem_write = 1 with A5 data; grant_i and grant_d never high together.
- Round-robin fairness:
  - Stimulus: both sides request continuously for 6 transactions.
  - Required: grant order I, D, I, D, I, D. With FIXED_PRIO = 1: D wins each tie and I is granted only when D is idle.
- Stale-request guard:
  - Stimulus: requester holds its request through the ready cycle and drops it one cycle later.
  - Required: exactly one memory transaction; RELEASE shows mem_read = 0 for 1 cycle.
- Watchdog:
  - Stimulus: TIMEOUT_CYC = 8; memory never asserts ready.
  - Required: timeout_err rises after 8 grant cycles; grant is held; timeout_err stays 1 after a later ready; cleared only by proc_reset.
- Abort and reset:
  - Stimulus: D drops its request mid-grant, then a late mem_ready arrives.
  - Required: d_mem_ready stays 0 and the next I request is granted normally.
  - Stimulus: proc_reset = 1 during GRANT_D.
  - Required: all outputs are 0 on the next edge and the state is IDLE.
